// File: rtl/mem_stage.sv
// mem_stage: memory stage of the MIPS pipeline.
// Holds the byte-addressable data memory, performs sub-word stores and
// extending loads, and registers the results into the MEM/WB register.
// A combinational debug port lets the debug unit dump memory at any time.

module mem_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8,
    parameter int NB_REG  = 5
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic               i_mem2reg,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_REG-1:0]  i_write_reg,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_mem_data
);

    localparam int DEPTH     = 2 ** NB_ADDR;
    localparam int NB_BYTE   = 8;
    localparam int NB_HALF   = 16;
    localparam int NB_LANES  = 4;

    // Width encodings coming from the EX/MEM register
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;

    // Data memory: one NB_DATA-bit word per entry, never reset
    logic [NB_DATA-1:0] r_mem [DEPTH];

    // Address decode signals
    logic [NB_ADDR-1:0] w_word_idx;
    logic [1:0]         w_byte_lane;
    logic               w_half_lane;
    logic               w_unused_addr;

    // Access width decode
    logic               w_is_byte;
    logic               w_is_half;

    // Store path
    logic [NB_LANES-1:0] w_byte_en;
    logic [NB_DATA-1:0]  w_store_data;
    logic                w_write_en;

    // Load path
    logic [NB_DATA-1:0]  w_rd_word;
    logic [NB_BYTE-1:0]  w_rd_byte;
    logic [NB_HALF-1:0]  w_rd_half;
    logic [NB_DATA-1:0]  w_load_data;

    // The word index skips the two byte-offset bits; anything above the
    // memory depth is dropped so addresses wrap around the memory.
    assign w_word_idx  = i_result[NB_ADDR+1:2];
    assign w_byte_lane = i_result[1:0];
    assign w_half_lane = i_result[1];

    // High address bits are intentionally ignored (wrap-around addressing)
    assign w_unused_addr = ^i_result[NB_DATA-1:NB_ADDR+2];

    assign w_is_byte = (i_width == WIDTH_BYTE);
    assign w_is_half = (i_width == WIDTH_HALF);

    // A halted pipeline or an asserted reset must never modify memory
    assign w_write_en = i_memWrite & ~i_halt & i_reset;

    // Select which byte lanes of the addressed word a store touches
    always_comb begin
        w_byte_en = '0;
        if (w_is_byte) begin
            case (w_byte_lane)
                2'd0:    w_byte_en = 4'b0001;
                2'd1:    w_byte_en = 4'b0010;
                2'd2:    w_byte_en = 4'b0100;
                default: w_byte_en = 4'b1000;
            endcase
        end else if (w_is_half) begin
            w_byte_en = w_half_lane ? 4'b1100 : 4'b0011;
        end else begin
            w_byte_en = 4'b1111;
        end
    end

    // Replicate the store operand so every enabled lane sees the right bits
    always_comb begin
        w_store_data = i_data4Mem;
        if (w_is_byte) begin
            w_store_data = {NB_LANES{i_data4Mem[NB_BYTE-1:0]}};
        end else if (w_is_half) begin
            w_store_data = {2{i_data4Mem[NB_HALF-1:0]}};
        end
    end

    // Synchronous byte-enabled write into the data memory
    always_ff @(posedge clk) begin
        if (w_write_en) begin
            for (int b = 0; b < NB_LANES; b++) begin
                if (w_byte_en[b]) begin
                    r_mem[w_word_idx][NB_BYTE*b +: NB_BYTE] <= w_store_data[NB_BYTE*b +: NB_BYTE];
                end
            end
        end
    end

    // Combinational read of the addressed word (sees the pre-edge contents)
    assign w_rd_word = r_mem[w_word_idx];

    // Pick the byte lane and halfword lane out of the read word
    always_comb begin
        w_rd_byte = w_rd_word[NB_BYTE-1:0];
        case (w_byte_lane)
            2'd0:    w_rd_byte = w_rd_word[7:0];
            2'd1:    w_rd_byte = w_rd_word[15:8];
            2'd2:    w_rd_byte = w_rd_word[23:16];
            default: w_rd_byte = w_rd_word[31:24];
        endcase
        w_rd_half = w_half_lane ? w_rd_word[31:16] : w_rd_word[15:0];
    end

    // Sign- or zero-extend sub-word loads; words pass through untouched
    always_comb begin
        w_load_data = w_rd_word;
        if (w_is_byte) begin
            if (i_sign_flag) begin
                w_load_data = {{(NB_DATA-NB_BYTE){w_rd_byte[NB_BYTE-1]}}, w_rd_byte};
            end else begin
                w_load_data = {{(NB_DATA-NB_BYTE){1'b0}}, w_rd_byte};
            end
        end else if (w_is_half) begin
            if (i_sign_flag) begin
                w_load_data = {{(NB_DATA-NB_HALF){w_rd_half[NB_HALF-1]}}, w_rd_half};
            end else begin
                w_load_data = {{(NB_DATA-NB_HALF){1'b0}}, w_rd_half};
            end
        end
    end

    // MEM/WB pipeline register: cleared by reset, frozen while halted
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_mem2reg   <= 1'b0;
            o_regWrite  <= 1'b0;
            o_write_reg <= '0;
            o_result    <= '0;
            o_mem_data  <= '0;
        end else if (!i_halt) begin
            o_mem2reg   <= i_mem2reg;
            o_regWrite  <= i_regWrite;
            o_write_reg <= i_write_reg;
            o_result    <= i_result;
            o_mem_data  <= w_load_data;
        end
    end

    // Debug read port is independent of halt and reset
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline memory stage.
- Consumes the EX/MEM register outputs: control bits, ALU result used as byte address, store data, destination register, access width and sign flag.
- Holds the byte-addressable data memory and performs SB/SH/SW stores and LB/LBU/LH/LHU/LW loads.
- Registers the results into the MEM/WB pipeline register.
- Provides a debug read port so the debug unit can dump memory while the pipeline is halted.

Parameters:
NB_DATA, 32, data/address width in bits
NB_ADDR, 8, word-address bits; memory depth = 2**NB_ADDR words of NB_DATA bits
NB_REG, 5, register index width

Ports:
clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous active-low reset
i_halt  input  1  1 = freeze MEM/WB register and block memory writes
i_mem2reg  input  1  from EX/MEM; 1 = write-back source is load data
i_memWrite  input  1  from EX/MEM; store request
i_regWrite  input  1  from EX/MEM; register-file write enable
i_width  input  2  00 byte, 01 halfword, 10/11 word
i_sign_flag  input  1  1 = sign-extend sub-word loads, 0 = zero-extend
i_result  input  NB_DATA  ALU result; byte address for loads/stores
i_data4Mem  input  NB_DATA  store data (rt after forwarding)
i_write_reg  input  NB_REG  destination register
i_dbg_addr  input  NB_ADDR  debug word address
o_dbg_data  output  NB_DATA  memory word at i_dbg_addr, combinational
o_mem2reg  output  1  MEM/WB copy of i_mem2reg
o_regWrite  output  1  MEM/WB copy of i_regWrite
o_write_reg  output  NB_REG  MEM/WB copy of i_write_reg
o_result  output  NB_DATA  MEM/WB copy of i_result
o_mem_data  output  NB_DATA  MEM/WB registered, extended load data

Behaviour:

Reset:
- i_reset low, asynchronous, clears every MEM/WB output to 0.
- Memory contents are not reset. Reads of never-written words are X until written.

Addressing:
- Word index = i_result[NB_ADDR+1:2]. Bits above that are ignored; addresses wrap modulo depth.
- Byte lane = i_result[1:0].
- Halfword lane = i_result[1]; i_result[0] is ignored.
- Word access ignores i_result[1:0]. No misalignment trap.

Store (i_memWrite=1 and i_halt=0):
- Synchronous write on the rising edge; only the selected lanes change.
- Byte: lane k[8k+7:8k] <= i_data4Mem[7:0].
- Halfword: i_result[1]=0 -> bits[15:0], i_result[1]=1 -> bits[31:16], loaded with i_data4Mem[15:0].
- Word: the full word is written.

Load:
- Combinational read of the addressed word, then lane select, then extension.
- Byte/half: i_sign_flag=1 replicates the top bit of the selected lane; i_sign_flag=0 zero-fills.
- Word: taken as is.
- The result is registered into o_mem_data on the next edge, independent of i_mem2reg. Downstream uses o_mem2reg to select between o_mem_data and o_result.

Latency and pipeline register:
- Inputs presented in cycle N appear on all MEM/WB outputs after edge N+1 (1 cycle).
- Write-then-read: a store at edge N is visible to a load presented in cycle N+1. Read-after-write is honoured with no bypass needed.

Halt:
- i_halt=1 holds all MEM/WB outputs and suppresses the memory write on that edge.
- On release, operation resumes with the inputs present in the first cycle after release.
- i_halt does not affect o_dbg_data.

Debug port:
- o_dbg_data = mem[i_dbg_addr], combinational, valid in any state including reset.

Simultaneous events:
- Reset asserted during a store: the store is not guaranteed; MEM/WB still clears.
- Debug read of a word being stored on the current edge returns the old value before the edge and the new value after.
- i_memWrite=1 with i_mem2reg=1 is not a legal control combination. Store takes effect; o_mem_data carries the pre-store word data.

Test Plan:
1. Reset low mid-run with o_result=0x1234 -> all outputs 0 immediately, without waiting for a clock edge. Release -> next instruction passes after 1 edge.
2. SW 0xDEADBEEF @0x10, then LW @0x10 next cycle with mem2reg=1, write_reg=8 -> o_mem_data=0xDEADBEEF, o_write_reg=8, o_regWrite=1.
3. After test 2:
   - LB @0x13 sign=1 -> 0xFFFFFFDE
   - LBU @0x13 -> 0x000000DE
   - LH @0x10 sign=1 -> 0xFFFFBEEF
   - LHU @0x12 -> 0x0000DEAD
4. SB 0x77 @0x11 over 0xDEADBEEF -> word reads 0xDEAD77EF. SH 0xABCD @0x12 -> word reads 0xABCD77EF. Confirm via debug port (i_dbg_addr=4).
5. i_halt=1 with SW 0x55 @0x20 and changing inputs -> memory word 8 unchanged, outputs frozen for 3 cycles. Release -> resume.
6. Address wrap: SW 0x1 @ (4·2**NB_ADDR + 0x8) -> o_dbg_data at word 2 = 0x1.
